// File: rtl/light_transition_controller_pkg.sv
// Shared lighting definitions: lamp/shade widths, controller states and bit helpers
// used by the transition controller.
package light_transition_controller_pkg;

    localparam int unsigned NUM_LAMPS = 16;
    localparam int unsigned SHADE_W   = 4;
    localparam int unsigned COUNT_W   = $clog2(NUM_LAMPS + 1);

    typedef logic [NUM_LAMPS-1:0] lamp_t;
    typedef logic [SHADE_W-1:0]   shade_t;
    typedef logic [COUNT_W-1:0]   lamp_cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // Isolates the lowest set bit; zero in gives zero out.
    function automatic lamp_t lowest_set(input lamp_t v);
        return v & (~v + lamp_t'(1));
    endfunction

    function automatic lamp_cnt_t popcount(input lamp_t v);
        lamp_cnt_t c;
        c = '0;
        for (int i = 0; i < NUM_LAMPS; i++) begin
            c = c + lamp_cnt_t'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/light_transition_controller_step_prescaler.sv
// N-cycle step counter: counts 0..N-1 while enabled and fires tick on the N-1 cycle.
module step_prescaler #(
    parameter int unsigned N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count_q;

    assign tick = en && (count_q == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= tick ? '0 : count_q + W'(1);
        end
    end

endmodule

// File: rtl/light_transition_controller.sv
// Applies a latched lamp pattern and shade level gradually: one lamp per lamp step,
// one shade level per shade step, then pulses done.
module light_transition_controller
    import light_transition_controller_pkg::*;
#(
    parameter int unsigned STEP_CYCLES  = 4,
    parameter int unsigned SHADE_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [NUM_LAMPS-1:0] target_state,
    input  logic [SHADE_W-1:0]   target_shade,
    output logic [NUM_LAMPS-1:0] lamp_out,
    output logic [SHADE_W-1:0]   shade_pos,
    output logic                 motor_up,
    output logic                 motor_down,
    output logic [COUNT_W-1:0]   lamp_count,
    output logic                 busy,
    output logic                 done
);

    state_e state_q;
    lamp_t  lamp_q, lamp_d, tgt_state_q;
    shade_t shade_q, shade_d, tgt_shade_q;
    logic   busy_q, done_q;

    logic running;
    logic presc_clr;
    logic lamp_tick;
    logic shade_tick;
    logic at_target;

    assign running   = (state_q == RUN);
    // A fresh run (from IDLE or DONE) restarts both step grids; a retarget does not.
    assign presc_clr = load && !running;
    assign at_target = (lamp_q == tgt_state_q) && (shade_q == tgt_shade_q);

    step_prescaler #(.N(STEP_CYCLES)) u_lamp_presc (
        .clk  (clk),
        .rst  (rst),
        .clr  (presc_clr),
        .en   (running),
        .tick (lamp_tick)
    );

    step_prescaler #(.N(SHADE_CYCLES)) u_shade_presc (
        .clk  (clk),
        .rst  (rst),
        .clr  (presc_clr),
        .en   (running),
        .tick (shade_tick)
    );

    always_comb begin
        // NOTE: defaults first so every path assigns lamp_d/shade_d; otherwise a latch is inferred.
        lamp_d  = lamp_q;
        shade_d = shade_q;
        if (lamp_tick) begin
            lamp_d = lamp_q ^ lowest_set(lamp_q ^ tgt_state_q);
        end
        if (shade_tick) begin
            if (shade_q < tgt_shade_q) begin
                shade_d = shade_q + shade_t'(1);
            end else if (shade_q > tgt_shade_q) begin
                shade_d = shade_q - shade_t'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking <= so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lamp_q      <= '0;
            shade_q     <= '0;
            tgt_state_q <= '0;
            tgt_shade_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            lamp_q  <= lamp_d;
            shade_q <= shade_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (load) begin
                        tgt_state_q <= target_state;
                        tgt_shade_q <= target_shade;
                        state_q     <= RUN;
                        busy_q      <= 1'b1;
                    end
                end
                RUN: begin
                    // A retarget keeps the run alive even if the old target was just met.
                    if (load) begin
                        tgt_state_q <= target_state;
                        tgt_shade_q <= target_shade;
                        busy_q      <= 1'b1;
                    end else if (at_target) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        busy_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (load) begin
                        tgt_state_q <= target_state;
                        tgt_shade_q <= target_shade;
                        state_q     <= RUN;
                        busy_q      <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign lamp_out   = lamp_q;
    assign shade_pos  = shade_q;
    assign motor_up   = running && (shade_q < tgt_shade_q);
    assign motor_down = running && (shade_q > tgt_shade_q);
    assign lamp_count = popcount(lamp_q);
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
